// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-bit 2-flop synchronizer, counter debounce and
// edge pulses. A sticky change flag lets the core poll for activity.

// One input bit: synchronizer, debounce counter and registered edge pulses.
module gpio_in_conditioner_lane #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall,
   output logic accept
);
   // At least one counter bit, even when DEBOUNCE_CYCLES is 1.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Fires on the edge that commits a new level. It depends only on registers,
   // so the top-level flag never sees a combinational path from the pins.
   assign accept = (s2 != level) && (cnt == CNT_MAX);

   // Sync, debounce count, level commit and one-cycle edge pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= pin;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) begin
            // The synced input is back at the committed level: drop the glitch.
            cnt <= '0;
         end else if (accept) begin
            // The new level has held long enough. Commit it and pulse.
            level <= s2;
            cnt   <= '0;
            rise  <= s2;
            fall  <= ~s2;
         end else begin
            // Cannot wrap: the count resets to zero when it reaches CNT_MAX.
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module gpio_in_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             change_flag_o
);
   logic [WIDTH-1:0] accept;

   for (genvar i = 0; i < WIDTH; i++) begin : gen_lane
      gpio_in_conditioner_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .pin   (pins_i[i]),
         .level (gpio_o[i]),
         .rise  (rise_o[i]),
         .fall  (fall_o[i]),
         .accept(accept[i])
      );
   end

   // Sticky change flag. It sets on the same edge gpio_o updates, and a set
   // beats a coincident clear so no transition is ever lost.
   always_ff @(posedge clk) begin
      if (reset)
         change_flag_o <= 1'b0;
      else if (|accept)
         change_flag_o <= 1'b1;
      else if (clr_i)
         change_flag_o <= 1'b0;
   end
endmodule
